pc_next_unit: RTL

Program-counter register and next-PC selection for the single-cycle core. It consumes the PC-relative target produced by the PC-plus-immediate adder and the ALU result for register-indirect jumps, and registers the next fetch address. It also handles pipeline hold (stall), misaligned-target traps and a retired-instruction counter. It sits between the branch/jump target logic and instruction memory.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/adder_subtractor_32bit.sv | 20 ++
 rtl/pc_next_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / next-PC unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_STEP             = 32'd4;
  localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;

  // Instruction fetch is word-granular; only bit 1 can be set by a legal
  // JALR/JAL/branch encoding, so that is the bit that marks a bad target.
  function automatic logic pc_misaligned(input logic [31:0] target);
    return target[1];
  endfunction

endpackage

// File: rtl/adder_subtractor_32bit.sv
// 32-bit two's-complement adder/subtractor with carry-out and signed overflow.
module adder_subtractor_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum,
  output logic        o_carry,
  output logic        o_overflow
);

  logic [31:0] w_b_eff;
  logic [32:0] w_full;

  assign w_b_eff    = i_b ^ {32{i_sub}};
  assign w_full     = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, i_sub};
  assign o_sum      = w_full[31:0];
  assign o_carry    = w_full[32];
  assign o_overflow = (i_a[31] == w_b_eff[31]) && (w_full[31] != i_a[31]);

endmodule

// File: rtl/pc_next_unit.sv
// Program counter, next-PC selection, retired-instruction counter and optional
// misaligned-target trap (built when PC_MISALIGN_TRAP_EN is defined).
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic        i_br_taken,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [31:0] i_pc_imm,
  input  logic [31:0] i_alu_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_pc_vld,
  output logic        o_misalign,
  output logic [31:0] o_epc,
  output logic [31:0] o_instret
);

  // state | meaning
  // BOOT  | post-reset bubble; o_pc = RESET_VECTOR, nothing executing
  // RUN   | o_pc executing; each non-stalled cycle retires one instruction
  // TRAP  | bubble after a misaligned redirect; next PC is TRAP_VECTOR

  pc_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instret;
  logic        r_pc_vld;
  logic [31:0] w_pc_four;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_run_tgt;
  logic        w_redirect;
  logic        w_retire;
  logic        w_trap;
  logic        w_unused_carry;
  logic        w_unused_ovf;

  adder_subtractor_32bit u_pc_inc (
    .i_a        (r_pc),
    .i_b        (PC_STEP),
    .i_sub      (1'b0),
    .o_sum      (w_pc_four),
    .o_carry    (w_unused_carry),
    .o_overflow (w_unused_ovf)
  );

  // JAL and taken branches share the PC-relative target.
  always_comb begin
    w_redirect  = 1'b0;
    w_redir_tgt = i_pc_imm;
    if (i_is_jalr) begin
      w_redirect  = 1'b1;
      w_redir_tgt = i_alu_data & ~32'h1;
    end else if (i_is_jal || (i_is_branch && i_br_taken)) begin
      w_redirect  = 1'b1;
      w_redir_tgt = i_pc_imm;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign w_trap    = w_redirect && pc_misaligned(w_redir_tgt);
  assign w_run_tgt = w_redirect ? w_redir_tgt : w_pc_four;
`else
  assign w_trap    = 1'b0;
  assign w_run_tgt = w_redirect ? (w_redir_tgt & ~32'h3) : w_pc_four;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (!i_stall) begin
          w_retire = 1'b1;
          w_pc_nxt = w_run_tgt;
          if (w_trap) w_state_nxt = TRAP;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      TRAP: begin
        w_state_nxt = RUN;
        w_pc_nxt    = TRAP_VECTOR;
      end
`endif
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VECTOR;
      r_pc_vld  <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_vld <= (w_state_nxt == RUN);
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic [31:0] r_epc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_misalign <= 1'b0;
      r_epc      <= 32'd0;
    end else if (w_retire && w_trap) begin
      r_misalign <= 1'b1;
      r_epc      <= r_pc;
    end
  end

  assign o_misalign = r_misalign;
  assign o_epc      = r_epc;
`else
  logic [31:0] w_unused_trap_vec;

  assign w_unused_trap_vec = TRAP_VECTOR;
  assign o_misalign        = 1'b0;
  assign o_epc             = 32'd0;
`endif

  assign o_pc      = r_pc;
  assign o_pc_four = w_pc_four;
  assign o_pc_vld  = r_pc_vld;
  assign o_instret = r_instret;

endmodule
